// File: rtl/debug_display_scan_pkg.sv
// Shared definitions for the debug display: segment glyphs, blank code and
// the hold/run state encoding.
package dbg_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low gfedcba glyphs, index 0 at the right; b and d are lowercase.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } hold_state_t;

  function automatic logic [6:0] nibble_to_seg(input logic [3:0] nibble);
    return SEG_GLYPH[nibble];
  endfunction

endpackage

// File: rtl/debug_display_scan_if.sv
// Probe/display bundle between the board top level and debug_display_scan.
interface debug_display_scan_if #(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SEL_W      = $clog2(NUM_CH)
);
  localparam int unsigned DATA_W = 4 * NUM_DIGITS;

  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [SEL_W-1:0]         sel;
  logic                     auto_scan;
  logic                     freeze_btn;
  logic [NUM_DIGITS*7-1:0]  hex;
  logic [SEL_W-1:0]         ch_idx;
  logic                     hold;

  modport master (
    output ch_data, sel, auto_scan, freeze_btn,
    input  hex, ch_idx, hold
  );

  modport slave (
    input  ch_data, sel, auto_scan, freeze_btn,
    output hex, ch_idx, hold
  );
endinterface

// File: rtl/debug_display_scan_hexcoder_reg.sv
// One registered 7-segment digit: nibble decode with blank override.
module hexcoder_reg
  import dbg_disp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_BLANK;
    end else if (en) begin
      seg <= blank ? SEG_BLANK : nibble_to_seg(nibble);
    end
  end

endmodule

// File: rtl/debug_display_scan.sv
// Board-debug display controller: selects one probe channel (manual or
// auto-scan), with a debounced freeze toggle, and drives registered 7-seg digits.
module debug_display_scan
  import dbg_disp_pkg::*;
#(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 50_000_000,
  parameter int unsigned DEB_CYC    = 1_000_000,
  parameter int unsigned BLANK_LZ   = 0,
  parameter int unsigned SEL_W      = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  debug_display_scan_if.slave  bus
);

  localparam int unsigned DATA_W = 4 * NUM_DIGITS;
  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam int unsigned DEB_W  = $clog2(DEB_CYC + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [SEL_W-1:0]  CH_LAST   = SEL_W'(NUM_CH - 1);

  logic [SEL_W-1:0]        sel_s1, sel_s2;
  logic                    auto_s1, auto_s2;
  logic                    btn_s1, btn_s2;
  logic                    btn_lvl;
  logic [DEB_W-1:0]        deb_cnt;
  logic                    press;
  hold_state_t             state, state_nxt;
  logic                    hold;
  logic                    run;
  logic [SEL_W-1:0]        ch_idx;
  logic [SCAN_W-1:0]       scan_cnt;
  logic [DATA_W-1:0]       sel_word;
  logic [DATA_W-1:0]       disp_word;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS*7-1:0] hex_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_s1  <= '0;
      sel_s2  <= '0;
      auto_s1 <= 1'b0;
      auto_s2 <= 1'b0;
      btn_s1  <= 1'b1;
      btn_s2  <= 1'b1;
    end else begin
      sel_s1  <= bus.sel;
      sel_s2  <= sel_s1;
      auto_s1 <= bus.auto_scan;
      auto_s2 <= auto_s1;
      btn_s1  <= bus.freeze_btn;
      btn_s2  <= btn_s1;
    end
  end

  // deb_cnt counts consecutive cycles the synced button differs from the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_lvl <= 1'b1;
      deb_cnt <= '0;
    end else if (btn_s2 == btn_lvl) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      btn_lvl <= btn_s2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign press = btn_lvl && !btn_s2 && (deb_cnt == DEB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (press) state_nxt = (state == ST_HOLD) ? ST_RUN : ST_HOLD;
  end

  // An accepted press also freezes its own cycle, so it beats a scan terminal count.
  always_comb begin
    hold = (state == ST_HOLD);
    run  = (state == ST_RUN) && !press;
  end

  // Out-of-range indices (non-power-of-2 NUM_CH) wrap straight to channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_idx   <= '0;
      scan_cnt <= '0;
    end else if (run) begin
      if (!auto_s2) begin
        ch_idx   <= sel_s2;
        scan_cnt <= '0;
      end else if (scan_cnt == SCAN_LAST) begin
        ch_idx   <= (ch_idx >= CH_LAST) ? '0 : ch_idx + 1'b1;
        scan_cnt <= '0;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (ch_idx == SEL_W'(k)) sel_word = bus.ch_data[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   disp_word <= '0;
    else if (run) disp_word <= sel_word;
  end

  always_comb begin
    blank = '0;
    for (int unsigned d = 1; d < NUM_DIGITS; d++) begin
      blank[d] = (BLANK_LZ != 0) && ((disp_word >> (4 * d)) == '0);
    end
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    hexcoder_reg u_hexcoder (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (!hold),
      .nibble (disp_word[d*4 +: 4]),
      .blank  (blank[d]),
      .seg    (hex_r[d*7 +: 7])
    );
  end

  assign bus.hex    = hex_r;
  assign bus.ch_idx = ch_idx;
  assign bus.hold   = hold;

endmodule

// File: doc/debug_display_scan.md
Name: debug_display_scan

Overview:
- Parametrised board-debug display controller that drives a bank of 7-segment digits from one of NUM_CH probe buses.
- Successor to the fixed 8-way combinational debug mux. Adds registered output, auto-scan mode with a dwell timer, a debounced freeze/hold toggle, optional leading-zero blanking and a channel-index readout.
- Sits at the board top level between the datapath probe buses (pc, instr, rd1, rd2, result, immext, alu_src_out, control, ...) and the HEX pins.

Parameters:
- NUM_CH, 8, number of probe channels (2..16).
- NUM_DIGITS, 8, number of 7-segment digits; data width per channel is DATA_W = 4*NUM_DIGITS.
- SCAN_DIV, 50_000_000, clock cycles each channel is shown in auto-scan mode (min 2).
- DEB_CYC, 1_000_000, cycles freeze_btn must be stable before it is accepted.
- BLANK_LZ, 0, 1 = blank leading zero digits (digit 0 is never blanked).
- SEL_W, $clog2(NUM_CH), width of the channel select and index.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ch_data  in  NUM_CH*DATA_W  flattened probes; channel k occupies bits [k*DATA_W +: DATA_W].
- sel  in  SEL_W  manual channel select (board switches).
- auto_scan  in  1  1 = auto-scan, 0 = manual (board switch, level).
- freeze_btn  in  1  raw push-button, active-low, asynchronous to clk.
- hex  out  NUM_DIGITS*7  segments, active-low; digit d occupies bits [d*7 +: 7], digit 0 = least-significant nibble.
- ch_idx  out  SEL_W  channel currently displayed.
- hold  out  1  1 = display frozen.

Behaviour:
- Reset (async assert, sync release): hex = all 1s (blank), ch_idx = 0, hold = 0, scan counter = 0, debounce state idle, synchronizers = 1.
- Input conditioning:
  - sel, auto_scan: 2-flop synchronizers.
  - freeze_btn: 2-flop synchronizer, then a debounce counter. The counter resets on any change and accepts the new level after DEB_CYC stable cycles.
  - An accepted press (1->0 on the debounced signal) toggles hold. Release has no effect.
- Channel index:
  - Manual mode: ch_idx <= synced sel every cycle (while not held).
  - Auto mode: scan counter counts 0..SCAN_DIV-1. At terminal count ch_idx <= ch_idx+1, wrapping from NUM_CH-1 to 0, and the counter restarts.
  - Manual->auto transition: scan starts from the current ch_idx with the counter cleared. Auto->manual: ch_idx follows sel on the next cycle.
  - sel >= NUM_CH (non-power-of-2 NUM_CH): ch_idx = sel is still reported, and the data word is forced to 0.
- Hold:
  - While hold=1, the display register, ch_idx and the scan counter are all frozen.
  - Mode and sel changes are ignored until release. On release, manual mode resumes from sel and auto mode resumes the count from where it stopped.
- Datapath:
  - disp_word register <= ch_data slice[ch_idx] when not held.
  - hex is registered from disp_word through NUM_DIGITS nibble decoders.
- Latency:
  - ch_data change -> hex change: 2 cycles (disp_word, then hex register).
  - sel change -> hex change: 5 cycles (2 sync, 1 ch_idx, 1 disp_word, 1 hex).
- Decode: nibbles 0-F map to standard active-low 7-segment glyphs (b and d lowercase).
- Blanking (BLANK_LZ=1): digits above the most-significant non-zero nibble output 7'h7F. A word of 0 shows a single "0" on digit 0.
- Reset mid-scan or mid-debounce: everything returns to reset values immediately; no partial toggle of hold.
- Simultaneous scan terminal count and accepted press in the same cycle: the press wins, hold=1, and ch_idx does not advance.

Decomposition:
- Shared package dbg_disp_pkg:
  - 16-entry active-low segment glyph constant.
  - SEG_BLANK = 7'h7F.
  - function nibble-to-segments.
- One sub-module: hexcoder_reg. One nibble in, plus blank and enable; registered 7-bit active-low out; reset to blank. Instantiated NUM_DIGITS times in a generate loop.
- Debounce is local logic inside the top module (single instance, not split out).

Test Plan:
- Use SCAN_DIV=4, DEB_CYC=3 in the bench.
- Reset then manual select: reset, check hex = all 1s. Set ch3 = 32'h1234ABCD and sel=3, wait 5 cycles. Expect digits 0..7 = D,C,B,A,4,3,2,1, so digit0 = 7'h21 and digit7 = 7'h79; ch_idx=3.
- Auto-scan wrap (NUM_CH=8): start at sel=6, set auto_scan=1. Expect ch_idx sequence 6,7,0,1 with exactly 4 cycles per step.
- Debounced freeze:
  - A 2-cycle glitch low on freeze_btn gives hold=0.
  - Holding low for 3+ cycles gives hold=1. While held, change ch3 to 32'hFFFFFFFF: hex is unchanged and ch_idx is frozen.
  - A second press gives hold=0, and the new value appears 2 cycles later.
- Leading-zero blank (BLANK_LZ=1): word 32'h000000A5 shows digits 7..2 = 7'h7F, digit1 = "A", digit0 = "5". Word 0 shows only digit0 = 7'h40.
- Edge cases:
  - Out-of-range select: with NUM_CH=6, sel=7 gives ch_idx=7 and all digits "0" (7'h40).
  - Async reset while held and mid-scan gives hold=0, ch_idx=0 and hex blank, the same cycle rst_n falls.
  - Press coinciding with scan terminal count gives hold=1 with ch_idx unchanged.
